// File: rtl/tiler_pkg.sv
// -----------------------------------------------------------------------------
// tiler_pkg
// Shared definitions for the tile scheduler slice.
//   - tiler_state_e : scheduler FSM states (IDLE, EMIT)
//   - tile_desc_t   : tile descriptor layout at the default widths
//   - cfg_valid()   : frame/tile configuration sanity check
// Optional feature macro used by the slice: TILER_SERPENTINE_EN (see
// tile_scheduler.sv); nothing in this package depends on it.
// -----------------------------------------------------------------------------
package tiler_pkg;

  localparam int TILER_WIDTH = 16;
  localparam int TILER_IDX_W = 24;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } tiler_state_e;

  // Descriptor layout at the default widths. The scheduler declares a local
  // copy of the same shape sized by its own WIDTH/IDX_W parameters.
  typedef struct packed {
    logic [TILER_WIDTH-1:0] row;
    logic [TILER_WIDTH-1:0] col;
    logic [TILER_WIDTH-1:0] rows;
    logic [TILER_WIDTH-1:0] cols;
    logic [TILER_IDX_W-1:0] index;
    logic                   last_col;
    logic                   last;
  } tile_desc_t;

  // A configuration is usable only when every dimension is non-zero and the
  // halo leaves a positive stride on both axes. Arguments are zero-extended
  // by the caller so one function serves any WIDTH up to 32.
  function automatic logic cfg_valid(input logic [31:0] h,
                                     input logic [31:0] w,
                                     input logic [31:0] tr,
                                     input logic [31:0] tc,
                                     input logic [31:0] ov);
    return (h != '0) && (w != '0) && (tr != '0) && (tc != '0) &&
           (ov < tr) && (ov < tc);
  endfunction

endpackage

// File: rtl/tile_axis_step.sv
// -----------------------------------------------------------------------------
// tile_axis_step
// One axis of the tile walk. Given the tile origin on this axis, the nominal
// tile size, the stride and the frame limit, it produces the clipped tile
// extent, whether this tile reaches the frame edge, and the next origin.
// All sums are formed at WIDTH+1 bits so origins near 2^WIDTH never wrap.
// No optional-feature macro (TILER_SERPENTINE_EN) is used here.
//
// Ports:
//   cur     in  WIDTH    tile origin on this axis
//   tile    in  WIDTH    nominal tile size on this axis
//   stride  in  WIDTH    distance between consecutive origins
//   limit   in  WIDTH    frame size on this axis
//   extent  out WIDTH    actual tile size, clipped at the frame edge
//   is_last out 1        tile reaches or passes the frame edge
//   next    out WIDTH+1  cur + stride, unwrapped
// -----------------------------------------------------------------------------
module tile_axis_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] tile,
  input  logic [WIDTH-1:0] stride,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] extent,
  output logic             is_last,
  output logic [WIDTH:0]   next
);

  logic [WIDTH:0] reach;

  assign reach   = {1'b0, cur} + {1'b0, tile};
  assign is_last = (reach >= {1'b0, limit});
  // Clip only when the tile would extend past the frame edge.
  assign extent  = (reach <= {1'b0, limit}) ? tile : (limit - cur);
  assign next    = {1'b0, cur} + {1'b0, stride};

endmodule

// File: rtl/tile_scheduler.sv
// -----------------------------------------------------------------------------
// tile_scheduler
// Walks a frame in (optionally overlapping) tiles and presents one tile
// descriptor at a time on a valid/ready interface. A descriptor is held
// stable until accepted; the next one is presented the cycle after.
//
// Optional feature: define TILER_SERPENTINE_EN to add the `serp` input.
// When serp is high at start, odd tile-rows are walked right-to-left.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            begin a frame (IDLE only)
//   abort            drop the current frame, no done pulse
//   frame_H/W        frame height / width in pixels
//   tile_rows        nominal tile height
//   tile_cols_max    nominal tile width
//   overlap          halo overlap on both axes
//   serp             serpentine enable (TILER_SERPENTINE_EN builds only)
//   tile_valid/ready descriptor handshake
//   tile_row_idx/col_idx   tile origin
//   tile_rows_out/cols_out actual tile extent
//   tile_index       linear tile number from 0
//   tile_last_col    last tile of the current tile-row (walk order)
//   tile_last        final tile of the frame
//   busy             frame in progress
//   done             one-cycle pulse after the final handshake
//   cfg_err          one-cycle pulse after a rejected start
// -----------------------------------------------------------------------------
module tile_scheduler
  import tiler_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] frame_H,
  input  logic [WIDTH-1:0] frame_W,
  input  logic [WIDTH-1:0] tile_rows,
  input  logic [WIDTH-1:0] tile_cols_max,
  input  logic [WIDTH-1:0] overlap,
`ifdef TILER_SERPENTINE_EN
  input  logic             serp,
`endif
  output logic             tile_valid,
  input  logic             tile_ready,
  output logic [WIDTH-1:0] tile_row_idx,
  output logic [WIDTH-1:0] tile_col_idx,
  output logic [WIDTH-1:0] tile_rows_out,
  output logic [WIDTH-1:0] tile_cols_out,
  output logic [IDX_W-1:0] tile_index,
  output logic             tile_last_col,
  output logic             tile_last,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef struct packed {
    logic [WIDTH-1:0] row;
    logic [WIDTH-1:0] col;
    logic [WIDTH-1:0] rows;
    logic [WIDTH-1:0] cols;
    logic [IDX_W-1:0] index;
    logic             last_col;
    logic             last;
  } desc_t;

  tiler_state_e     state;
  logic [WIDTH-1:0] cfg_h, cfg_w, cfg_tr, cfg_tc, cfg_ov;
  desc_t            desc_q;
  desc_t            ld_desc;
  logic [WIDTH:0]   nxt_row_q, nxt_col_q;

  logic             in_idle;
  logic             cfg_ok;
  logic [WIDTH-1:0] src_h, src_w, src_tr, src_tc, src_ov;
  logic [WIDTH-1:0] row_stride, col_stride;

  logic [WIDTH-1:0] ld_row, ld_col;
  logic             ld_rev;
  logic [WIDTH-1:0] ld_rows, ld_cols;
  logic             ld_row_last, ld_col_fwd_last;
  logic [WIDTH:0]   ld_row_next, ld_col_next;

  logic             serp_q;
  logic             cur_rev;

  assign in_idle = (state == IDLE);
  assign busy    = (state == EMIT);

  // In IDLE the descriptor being prepared is the first tile of a frame that
  // has not been latched yet, so the live inputs feed the datapath; once
  // running, only the latched copy is used.
  assign src_h  = in_idle ? frame_H       : cfg_h;
  assign src_w  = in_idle ? frame_W       : cfg_w;
  assign src_tr = in_idle ? tile_rows     : cfg_tr;
  assign src_tc = in_idle ? tile_cols_max : cfg_tc;
  assign src_ov = in_idle ? overlap       : cfg_ov;

  assign row_stride = src_tr - src_ov;
  assign col_stride = src_tc - src_ov;

  assign cfg_ok = cfg_valid(32'(frame_H), 32'(frame_W), 32'(tile_rows),
                            32'(tile_cols_max), 32'(overlap));

  // Origin of the descriptor that will be loaded at the next load event:
  // (0,0) on start, otherwise the successor of the presented tile. Row
  // origins that are only used when the frame continues can be truncated
  // safely, since continuing implies the unwrapped sum is below the limit.
  // A reversed row steps left from the presented column; a new reversed row
  // starts on the same column where the forward row ended.
  always_comb begin
    ld_row = '0;
    ld_col = '0;
    ld_rev = 1'b0;
    if (!in_idle) begin
      if (!desc_q.last_col) begin
        ld_row = desc_q.row;
        ld_rev = cur_rev;
        ld_col = cur_rev ? (desc_q.col - col_stride) : nxt_col_q[WIDTH-1:0];
      end else begin
        ld_row = nxt_row_q[WIDTH-1:0];
        ld_rev = serp_q && !cur_rev;
        ld_col = ld_rev ? desc_q.col : '0;
      end
    end
  end

  tile_axis_step #(.WIDTH(WIDTH)) u_row_step (
    .cur     (ld_row),
    .tile    (src_tr),
    .stride  (row_stride),
    .limit   (src_h),
    .extent  (ld_rows),
    .is_last (ld_row_last),
    .next    (ld_row_next)
  );

  tile_axis_step #(.WIDTH(WIDTH)) u_col_step (
    .cur     (ld_col),
    .tile    (src_tc),
    .stride  (col_stride),
    .limit   (src_w),
    .extent  (ld_cols),
    .is_last (ld_col_fwd_last),
    .next    (ld_col_next)
  );

  // Assemble the next descriptor. A reversed row ends at column 0 rather
  // than at the right frame edge.
  always_comb begin
    ld_desc          = '0;
    ld_desc.row      = ld_row;
    ld_desc.col      = ld_col;
    ld_desc.rows     = ld_rows;
    ld_desc.cols     = ld_cols;
    ld_desc.index    = in_idle ? '0 : (desc_q.index + 1'b1);
    ld_desc.last_col = ld_rev ? (ld_col == '0) : ld_col_fwd_last;
    ld_desc.last     = ld_desc.last_col && ld_row_last;
  end

  // Scheduler FSM. Abort takes priority over everything, including a
  // handshake in the same cycle and a start presented alongside it. In EMIT
  // tile_valid is always high, so tile_ready alone marks a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tile_valid <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      desc_q     <= '0;
      nxt_row_q  <= '0;
      nxt_col_q  <= '0;
      cfg_h      <= '0;
      cfg_w      <= '0;
      cfg_tr     <= '0;
      cfg_tc     <= '0;
      cfg_ov     <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (cfg_ok) begin
              state      <= EMIT;
              tile_valid <= 1'b1;
              desc_q     <= ld_desc;
              nxt_row_q  <= ld_row_next;
              nxt_col_q  <= ld_col_next;
              cfg_h      <= frame_H;
              cfg_w      <= frame_W;
              cfg_tr     <= tile_rows;
              cfg_tc     <= tile_cols_max;
              cfg_ov     <= overlap;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (abort) begin
            state      <= IDLE;
            tile_valid <= 1'b0;
            desc_q     <= '0;
          end else if (tile_ready) begin
            if (desc_q.last) begin
              state      <= IDLE;
              tile_valid <= 1'b0;
              done       <= 1'b1;
              desc_q     <= '0;
            end else begin
              desc_q    <= ld_desc;
              nxt_row_q <= ld_row_next;
              nxt_col_q <= ld_col_next;
            end
          end
        end
        default: begin
          state      <= IDLE;
          tile_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef TILER_SERPENTINE_EN
  // Serpentine bookkeeping: the per-frame enable and the direction of the
  // row currently being presented. Updated on the same events that load a
  // new descriptor.
  always_ff @(posedge clk) begin
    if (rst) begin
      serp_q  <= 1'b0;
      cur_rev <= 1'b0;
    end else if (in_idle && start && !abort && cfg_ok) begin
      serp_q  <= serp;
      cur_rev <= 1'b0;
    end else if (!in_idle && !abort && tile_ready && !desc_q.last) begin
      cur_rev <= ld_rev;
    end
  end
`else
  // Raster-only build: every row is walked left-to-right.
  assign serp_q  = 1'b0;
  assign cur_rev = 1'b0;
`endif

  assign tile_row_idx  = desc_q.row;
  assign tile_col_idx  = desc_q.col;
  assign tile_rows_out = desc_q.rows;
  assign tile_cols_out = desc_q.cols;
  assign tile_index    = desc_q.index;
  assign tile_last_col = desc_q.last_col;
  assign tile_last     = desc_q.last;

endmodule

// File: tb/tb_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tile_scheduler
// Self-checking bench for tile_scheduler (default raster build, macro
// TILER_SERPENTINE_EN undefined). Expected descriptor sequences come from a
// nested-loop walk of the frame kept in a queue.
// -----------------------------------------------------------------------------
module tb_tile_scheduler;

  localparam int WIDTH = 16;
  localparam int IDX_W = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] frame_H, frame_W, tile_rows, tile_cols_max, overlap;
  logic             tile_valid;
  logic             tile_ready;
  logic [WIDTH-1:0] tile_row_idx, tile_col_idx, tile_rows_out, tile_cols_out;
  logic [IDX_W-1:0] tile_index;
  logic             tile_last_col, tile_last, busy, done, cfg_err;

  always #5 clk = ~clk;

  tile_scheduler #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .frame_H       (frame_H),
    .frame_W       (frame_W),
    .tile_rows     (tile_rows),
    .tile_cols_max (tile_cols_max),
    .overlap       (overlap),
    .tile_valid    (tile_valid),
    .tile_ready    (tile_ready),
    .tile_row_idx  (tile_row_idx),
    .tile_col_idx  (tile_col_idx),
    .tile_rows_out (tile_rows_out),
    .tile_cols_out (tile_cols_out),
    .tile_index    (tile_index),
    .tile_last_col (tile_last_col),
    .tile_last     (tile_last),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err)
  );

  typedef struct {
    int row;
    int col;
    int rows;
    int cols;
    int index;
    bit last_col;
    bit last;
  } exp_desc_t;

  exp_desc_t exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference walk: rows of tiles top to bottom, tiles left to right, with
  // plain integer arithmetic so nothing can wrap.
  function automatic void buildModel(input int h, input int w, input int tr,
                                     input int tc, input int ov);
    int r, c, n;
    bit row_end, col_end;
    exp_desc_t d;
    exp_q.delete();
    n = 0;
    r = 0;
    row_end = 1'b0;
    while (!row_end) begin
      row_end = (r + tr >= h);
      c = 0;
      col_end = 1'b0;
      while (!col_end) begin
        col_end    = (c + tc >= w);
        d.row      = r;
        d.col      = c;
        d.rows     = (r + tr <= h) ? tr : h - r;
        d.cols     = (c + tc <= w) ? tc : w - c;
        d.index    = n;
        d.last_col = col_end;
        d.last     = col_end && row_end;
        exp_q.push_back(d);
        n++;
        c += tc - ov;
      end
      r += tr - ov;
    end
  endfunction

  task automatic applyStimulus(input int h, input int w, input int tr,
                               input int tc, input int ov);
    frame_H       = 16'(h);
    frame_W       = 16'(w);
    tile_rows     = 16'(tr);
    tile_cols_max = 16'(tc);
    overlap       = 16'(ov);
    start         = 1'b1;
  endtask

  // Runs one frame against exp_q, which must already be built and the start
  // already driven. Config inputs and start are scrambled while busy to
  // show they are ignored. abort_at >= 0 aborts while that index is shown.
  task automatic runFrame(input bit rand_ready, input int abort_at);
    int  ptr;
    int  budget;
    bit  rdy;
    ptr    = 0;
    budget = 6 * exp_q.size() + 40;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'(1));
    while (ptr < exp_q.size()) begin
      if (budget == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL cycle_budget observed=%0d tiles expected=%0d", ptr, exp_q.size());
        break;
      end
      budget--;
      frame_H       = 16'($urandom);
      frame_W       = 16'($urandom);
      tile_rows     = 16'($urandom);
      tile_cols_max = 16'($urandom);
      overlap       = 16'($urandom);
      checkOutput("tile_valid", 32'(tile_valid), 32'(1));
      checkOutput("row_idx",    32'(tile_row_idx),  exp_q[ptr].row);
      checkOutput("col_idx",    32'(tile_col_idx),  exp_q[ptr].col);
      checkOutput("rows_out",   32'(tile_rows_out), exp_q[ptr].rows);
      checkOutput("cols_out",   32'(tile_cols_out), exp_q[ptr].cols);
      checkOutput("tile_index", 32'(tile_index),    exp_q[ptr].index);
      checkOutput("last_col",   32'(tile_last_col), 32'(exp_q[ptr].last_col));
      checkOutput("tile_last",  32'(tile_last),     32'(exp_q[ptr].last));
      checkOutput("done_mid",   32'(done), 32'(0));
      if (ptr == abort_at) begin
        abort      = 1'b1;
        tile_ready = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        abort      = 1'b0;
        start      = 1'b0;
        tile_ready = 1'b0;
        checkOutput("abort_valid", 32'(tile_valid), 32'(0));
        checkOutput("abort_busy",  32'(busy),       32'(0));
        checkOutput("abort_done",  32'(done),       32'(0));
        @(posedge clk); #1;
        checkOutput("abort_done2",  32'(done),       32'(0));
        checkOutput("abort_valid2", 32'(tile_valid), 32'(0));
        return;
      end
      rdy        = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tile_ready = rdy;
      start      = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      start = 1'b0;
      if (rdy) ptr++;
    end
    tile_ready = 1'b0;
    checkOutput("end_valid", 32'(tile_valid), 32'(0));
    checkOutput("end_busy",  32'(busy),       32'(0));
    checkOutput("end_done",  32'(done),       32'(1));
    @(posedge clk); #1;
    checkOutput("done_once", 32'(done),       32'(0));
    checkOutput("end_cfg",   32'(cfg_err),    32'(0));
  endtask

  task automatic checkCfgErr(input string tag, input int h, input int w,
                             input int tr, input int tc, input int ov);
    applyStimulus(h, w, tr, tc, ov);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, "_pulse"}, 32'(cfg_err),    32'(1));
    checkOutput({tag, "_busy"},  32'(busy),       32'(0));
    checkOutput({tag, "_valid"}, 32'(tile_valid), 32'(0));
    @(posedge clk); #1;
    checkOutput({tag, "_clear"}, 32'(cfg_err),    32'(0));
    checkOutput({tag, "_idle"},  32'(tile_valid), 32'(0));
  endtask

  initial begin
    int h, w, tr, tc, ov, mn;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    tile_ready = 1'b0;
    frame_H    = '0;
    frame_W    = '0;
    tile_rows  = '0;
    tile_cols_max = '0;
    overlap    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state: every output zero.
    checkOutput("rst_valid",    32'(tile_valid),    32'(0));
    checkOutput("rst_busy",     32'(busy),          32'(0));
    checkOutput("rst_done",     32'(done),          32'(0));
    checkOutput("rst_cfg_err",  32'(cfg_err),       32'(0));
    checkOutput("rst_row",      32'(tile_row_idx),  32'(0));
    checkOutput("rst_col",      32'(tile_col_idx),  32'(0));
    checkOutput("rst_rows",     32'(tile_rows_out), 32'(0));
    checkOutput("rst_cols",     32'(tile_cols_out), 32'(0));
    checkOutput("rst_index",    32'(tile_index),    32'(0));
    checkOutput("rst_last_col", 32'(tile_last_col), 32'(0));
    checkOutput("rst_last",     32'(tile_last),     32'(0));

    // 10x10, 4x4, no overlap, ready held high.
    buildModel(10, 10, 4, 4, 0);
    applyStimulus(10, 10, 4, 4, 0);
    runFrame(1'b0, -1);

    // Same frame with random backpressure.
    buildModel(10, 10, 4, 4, 0);
    applyStimulus(10, 10, 4, 4, 0);
    runFrame(1'b1, -1);

    // Overlap 1: origins 0,3,6 with full extents.
    buildModel(10, 10, 4, 4, 1);
    applyStimulus(10, 10, 4, 4, 1);
    runFrame(1'b1, -1);

    // Tall thin frame: 16 tile-rows, last one 10 high.
    buildModel(250, 16, 16, 16, 0);
    applyStimulus(250, 16, 16, 16, 0);
    runFrame(1'b0, -1);

    // Column origin + tile exceeds 2^16: last tile must clip, not wrap.
    buildModel(16, 65530, 16, 16384, 0);
    applyStimulus(16, 65530, 16, 16384, 0);
    runFrame(1'b1, -1);

    // Rejected configurations.
    checkCfgErr("cfg_ov", 10, 10, 4, 4, 4);
    checkCfgErr("cfg_w0", 10, 0, 4, 4, 0);

    // start together with abort in IDLE is ignored.
    applyStimulus(10, 10, 4, 4, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_busy", 32'(busy),    32'(0));
    checkOutput("start_abort_cfg",  32'(cfg_err), 32'(0));

    // Abort while tile 4 is shown, then a fresh frame from index 0.
    buildModel(10, 10, 4, 4, 0);
    applyStimulus(10, 10, 4, 4, 0);
    runFrame(1'b0, 4);
    buildModel(10, 10, 4, 4, 0);
    applyStimulus(10, 10, 4, 4, 0);
    runFrame(1'b0, -1);

    // Random valid configurations with random backpressure.
    for (int k = 0; k < 6; k++) begin
      h  = $urandom_range(1, 40);
      w  = $urandom_range(1, 40);
      tr = $urandom_range(1, 12);
      tc = $urandom_range(1, 12);
      mn = (tr < tc) ? tr : tc;
      ov = $urandom_range(0, mn - 1);
      buildModel(h, w, tr, tc, ov);
      applyStimulus(h, w, tr, tc, ov);
      runFrame(1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
